hist_frame_seq: RTL
===================

# hist_frame_seq

Frame sequencer for the 8-bit image histogram unit.
- Clears the histogram, streams exactly one frame of pixels into it through a valid/ready handshake, then reads every bin back in index order onto a valid/ready output stream.
- Sits between the pixel source (image memory / SIMD lane) and the histogram unit, and owns the histogram's `dataIn`, `enable`, `resetm` and `histAddr` pins.

## Interface
Parameters:
- `NUM_BINS`, 8, histogram bin count; power of two, 2..256.
- `FRAME_PIXELS`, 1024, pixels per frame; 1..65535.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to process a frame; ignored while `busy`=1.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle after `done`.
- `pix_in`  in  8  pixel value.
- `pix_valid`  in  1  `pix_in` is valid.
- `pix_ready`  out  1  high only in state ACCUM.
- `hist_data_in`  out  8  drives histogram `dataIn`; registered.
- `hist_enable`  out  1  drives histogram `enable`; registered, one cycle per accepted pixel.
- `hist_resetm`  out  1  drives histogram `resetm`; one-cycle clear pulse.
- `hist_addr`  out  $clog2(NUM_BINS)  drives histogram `histAddr`.
- `hist_out`  in  16  histogram `histOut`; registered, one cycle after `hist_addr`.
- `bin_valid`  out  1  `bin_count` / `bin_index` are valid.
- `bin_ready`  in  1  consumer accepts the bin.
- `bin_count`  out  16  bin value (raw or cumulative, see Configuration).
- `bin_index`  out  $clog2(NUM_BINS)  bin number, 0..NUM_BINS-1.
- `bin_last`  out  1  high with `bin_valid` for bin NUM_BINS-1.
- `done`  out  1  one-cycle pulse after the last bin is accepted.

## Operation
States: IDLE, CLR, ACCUM, SETTLE, RD_ADDR, RD_WAIT, RD_OUT, FIN.
- **IDLE:** on `start`, go to CLR.
- **CLR:** `hist_resetm`=1 for exactly one cycle; clear the pixel counter and bin index; go to ACCUM.
- **ACCUM:** `pix_ready`=1. Each `pix_valid & pix_ready` edge does three things:
  - registers `hist_data_in`<=`pix_in`;
  - sets `hist_enable`<=1 for the next cycle only (0 otherwise);
  - increments the pixel counter.
  - On the edge that accepts pixel FRAME_PIXELS, go to SETTLE with `pix_ready`=0 from then on.
- **SETTLE:** one cycle, so the final `hist_enable` write lands; go to RD_ADDR.
- **Histogram read mapping (fixed):** address a returns bin (a+1) mod NUM_BINS. To read bin k, drive `hist_addr`=(k-1) mod NUM_BINS, i.e. NUM_BINS-1 for k=0. `hist_addr` is held for the RD_ADDR and RD_WAIT cycles.
- **RD_ADDR** -> **RD_WAIT** -> **RD_OUT:** on the RD_WAIT->RD_OUT edge, capture `hist_out` into the output holding register.
- **RD_OUT:** `bin_valid`=1. `bin_count`, `bin_index` and `bin_last` are stable until `bin_ready`. On `bin_valid & bin_ready`:
  - if k<NUM_BINS-1, increment k and go to RD_ADDR;
  - otherwise go to FIN.
- **FIN:** `done`=1 for one cycle; go to IDLE.

Boundary and arithmetic rules:
- Pixels offered outside ACCUM are not consumed.
- The pixel counter is 16 bits and compares for equality with FRAME_PIXELS; no wrap.
- `start` while `busy` has no effect, including `start` coincident with `done`.
- `reset` mid-frame: all state returns to IDLE immediately and the frame is abandoned. Histogram contents are undefined until the next CLR.

## Timing
- Reset values: `busy`, `pix_ready`, `hist_enable`, `hist_resetm`, `bin_valid`, `bin_last`, `done` = 0. `hist_data_in`, `hist_addr`, `bin_count`, `bin_index` = 0. State = IDLE.
- `start` at edge E0: CLR during E0..E1; `pix_ready`=1 from E1.
- Accept at edge E: `hist_enable` is high during E..E+1; histogram increments at E+1.
- With continuous `pix_valid`, ACCUM takes FRAME_PIXELS cycles.
- Per bin: 3 cycles minimum (RD_ADDR, RD_WAIT, RD_OUT with `bin_ready`=1).
- Minimum frame latency, `start` to `done`: 1 + FRAME_PIXELS + 1 + 3·NUM_BINS + 1 cycles.
- All outputs are registered or decoded from state; no input-to-output combinational path.

## Configuration
- `HIST_FRAME_SEQ_CDF_EN` undefined: `bin_count` = raw bin k count.
- Defined: `bin_count` = cumulative sum of bins 0..k.
  - The 16-bit accumulator is cleared in CLR and saturates at 16'hFFFF.
  - Accumulation happens at capture, so `bin_count` for bin NUM_BINS-1 equals the frame total (unless saturated).
  - No timing change.

## Test plan
- Reset, then idle 10 cycles -> all outputs 0, `pix_ready`=0.
- NUM_BINS=8, FRAME_PIXELS=16, pixels 0,32,64,…,224 each twice, `bin_ready`=1 -> bins 0..7 each `bin_count`=2, `bin_index` 0..7 in order, `bin_last` only on index 7, `done` at cycle 1+16+1+24+1 after `start`.
- Pixels all 255 with `pix_valid` toggling every other cycle -> exactly 16 accepted; bin 7=16, bins 0..6=0; `hist_enable` pulses exactly 16 times.
- `bin_ready` held 0 for 5 cycles on bin 3 -> `bin_valid`, `bin_count`, `bin_index` stable for those cycles; no bin skipped or duplicated.
- `reset` asserted mid-ACCUM after 7 pixels, then a new `start` -> one-cycle `hist_resetm` pulse; the new frame's bins reflect only the new pixels.
- `HIST_FRAME_SEQ_CDF_EN` defined, same stimulus as scenario 2 -> `bin_count` = 2,4,6,…,16; `start` pulsed during readout is ignored.

Source files
------------

// File: rtl/hist_frame_seq.sv
// hist_frame_seq: frame sequencer for the 8-bit image histogram unit.
//
// Clears the histogram, streams exactly FRAME_PIXELS pixels into it over a
// valid/ready handshake, then reads every bin back in index order onto a
// valid/ready output stream and pulses done.
//
// Parameters:
//   NUM_BINS      histogram bin count, power of two, 2..256
//   FRAME_PIXELS  pixels per frame, 1..65535
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   start / busy / done      frame request, in-progress flag, completion pulse
//   pix_in/valid/ready       pixel input stream (consumed only in ACCUM)
//   hist_data_in, hist_enable, hist_resetm, hist_addr, hist_out
//                            histogram unit pins (dataIn, enable, resetm,
//                            histAddr, histOut)
//   bin_valid/ready, bin_count, bin_index, bin_last
//                            bin readout stream
//
// Build option:
//   HIST_FRAME_SEQ_CDF_EN    when defined, bin_count carries the saturating
//                            cumulative sum of bins 0..k instead of the raw
//                            bin k count.
module hist_frame_seq #(
  parameter int unsigned NUM_BINS     = 8,
  parameter int unsigned FRAME_PIXELS = 1024,
  localparam int unsigned AW          = $clog2(NUM_BINS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  input  logic [7:0]    pix_in,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic [7:0]    hist_data_in,
  output logic          hist_enable,
  output logic          hist_resetm,
  output logic [AW-1:0] hist_addr,
  input  logic [15:0]   hist_out,
  output logic          bin_valid,
  input  logic          bin_ready,
  output logic [15:0]   bin_count,
  output logic [AW-1:0] bin_index,
  output logic          bin_last,
  output logic          done
);

  localparam logic [15:0]   FrameCnt = 16'(FRAME_PIXELS);
  localparam logic [AW-1:0] LastBin  = AW'(NUM_BINS - 1);

  typedef enum logic [2:0] {
    StIdle, StClr, StAccum, StSettle, StRdAddr, StRdWait, StRdOut, StFin
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pix_cnt_q;
  logic [15:0] pix_cnt_inc;
  logic [15:0] capture_val;

  assign pix_cnt_inc = pix_cnt_q + 16'd1;

`ifdef HIST_FRAME_SEQ_CDF_EN
  // bin_count doubles as the running sum; it is cleared in CLR.
  logic [16:0] cdf_sum;
  assign cdf_sum     = {1'b0, bin_count} + {1'b0, hist_out};
  assign capture_val = cdf_sum[16] ? 16'hFFFF : cdf_sum[15:0];
`else
  assign capture_val = hist_out;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StClr;
      StClr:    state_d = StAccum;
      StAccum:  if (pix_valid && (pix_cnt_inc == FrameCnt)) state_d = StSettle;
      StSettle: state_d = StRdAddr;
      StRdAddr: state_d = StRdWait;
      StRdWait: state_d = StRdOut;
      StRdOut:  if (bin_ready) state_d = (bin_index == LastBin) ? StFin : StRdAddr;
      StFin:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pix_cnt_q    <= 16'd0;
      busy         <= 1'b0;
      pix_ready    <= 1'b0;
      hist_data_in <= 8'd0;
      hist_enable  <= 1'b0;
      hist_resetm  <= 1'b0;
      hist_addr    <= '0;
      bin_valid    <= 1'b0;
      bin_count    <= 16'd0;
      bin_index    <= '0;
      bin_last     <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Flag outputs are registered copies of the next-state decode.
      busy        <= (state_d != StIdle);
      pix_ready   <= (state_d == StAccum);
      hist_resetm <= (state_d == StClr);
      bin_valid   <= (state_d == StRdOut);
      done        <= (state_d == StFin);
      bin_last    <= (state_d == StRdOut) && (bin_index == LastBin);
      hist_enable <= 1'b0;

      case (state_q)
        StClr: begin
          pix_cnt_q <= 16'd0;
          bin_index <= '0;
          bin_count <= 16'd0;
        end
        StAccum: begin
          if (pix_valid) begin
            hist_data_in <= pix_in;
            hist_enable  <= 1'b1;
            pix_cnt_q    <= pix_cnt_inc;
          end
        end
        // Address a returns bin a+1, so bin 0 is read from the top address.
        StSettle: hist_addr <= LastBin;
        StRdWait: bin_count <= capture_val;
        StRdOut: begin
          if (bin_ready && (bin_index != LastBin)) begin
            bin_index <= bin_index + 1'b1;
            hist_addr <= bin_index;  // (k+1)-1
          end
        end
        default: ;
      endcase
    end
  end

endmodule
